sqrt_rr_scheduler: RTL
======================

// Module: sqrt_rr_scheduler
// PURPOSE
//  Shares one 64->32-bit iterative square-root unit among N_REQ requesters
//  (e.g. |I|^2+|Q|^2 magnitude channels) with round-robin fairness.
//  Each requester gets one REQ/ACK transaction.
//  The block drives the unit's level START/FIN handshake, latches its COUNT result and returns it.
//  It sits between the per-channel accumulators and the sqrt unit, and aborts hung operations on timeout.
// PARAMETERS
//  N_REQ    4    number of requesters (>=2)
//  W_IN     64   radicand width per requester
//  W_OUT    32   root width
//  TIMEOUT  64   max ISSUE cycles waiting for RAD_FIN before abort (>=40)
// PORTS
//  CLK        in   1            clock, all logic on rising edge
//  RESET      in   1            synchronous, active-high reset
//  REQ        in   N_REQ        per-requester request level
//  X_IN       in   N_REQ*W_IN   radicands; requester i at [i*W_IN +: W_IN]
//  ACK        out  N_REQ        one-cycle done pulse to the granted requester
//  RESULT     out  W_OUT        root; valid in ACK cycle, held until next ACK
//  ERR        out  1            one-cycle pulse with ACK when op timed out
//  BUSY       out  1            high in any state other than IDLE
//  GRANT_ID   out  clog2(N_REQ) index of current/last granted requester
//  RAD_START  out  1            level START to sqrt unit
//  RAD_X      out  W_IN         radicand to sqrt unit, stable while RAD_START=1
//  RAD_FIN    in   1            FIN from sqrt unit
//  RAD_COUNT  in   W_OUT        COUNT (root) from sqrt unit
// BEHAVIOUR
//  Reset: all outputs 0. Also cleared: state=IDLE, rr pointer=0, timeout counter=0.
//  FSM states: IDLE, ISSUE, RELEASE.
//  IDLE:
//   - Grants only when RAD_FIN=0 and |REQ.
//   - Winner is the first i with REQ[i]=1, searching ptr, ptr+1, ... ptr+N_REQ-1 (mod N_REQ).
//   - Next edge: GRANT_ID<=i, RAD_X<=X_IN[i], RAD_START<=1, ptr<=(i+1) mod N_REQ, cnt<=0, ->ISSUE.
//   - X_IN[i] is sampled once, at grant. Later changes are ignored.
//  ISSUE: RAD_START=1 and cnt increments each cycle.
//   - If RAD_FIN=1: RESULT<=RAD_COUNT, ACK[GRANT_ID]<=1 for one cycle, RAD_START<=0, ->RELEASE.
//   - Else if cnt==TIMEOUT-1: RESULT<='1, ACK pulse with ERR=1, RAD_START<=0, ->RELEASE.
//  RELEASE: RAD_START=0. ->IDLE on the first cycle RAD_FIN=0.
//   - Do not re-grant until the unit has dropped FIN.
//  Latency: ACK rises 1 cycle after RAD_FIN is first seen high in ISSUE.
//   - Nominal with this sqrt unit: 35 cycles from REQ sampled in IDLE to ACK.
//   - Back-to-back grant period: 37 cycles.
//  Handshake rules:
//   - REQ is sampled only in IDLE.
//   - Dropping REQ after grant does not cancel the op; ACK still pulses.
//   - A requester holding REQ through its ACK is treated as a new request and waits its rr turn.
//  Simultaneous REQ: only the rr winner is served; the others wait, with no loss.
//  Fairness: any continuously asserted REQ is served within N_REQ grants.
//  ptr wraps from N_REQ-1 to 0.
//  Reset mid-operation:
//   - RAD_START drops next edge and any in-flight result is discarded (no ACK).
//   - IDLE then waits for RAD_FIN=0 before any new grant.
//  ERR is never set without ACK. ACK is one-hot or zero.
//  RESULT is the unsigned floor(sqrt(X)) as returned by the unit; no width extension.
// TESTING
//  1 Single request:
//    REQ=0001, X_IN[0]=64'd1_000_000 -> ACK=0001 once, RESULT=1000, ERR=0, BUSY low after RELEASE.
//  2 All requesting, ptr=0:
//    REQ=1111, held -> ACK order 0,1,2,3,0,...
//    X=0/1/2^62/2^64-1 -> RESULT 0, 1, 2^31, 32'hFFFF_FFFF.
//  3 Fairness:
//    REQ[0] toggles on every ACK, REQ[2] held -> grants alternate 0,2,0,2; REQ[2] wait <=2 grants.
//  4 Timeout:
//    model holds RAD_FIN=0 -> after TIMEOUT cycles in ISSUE, ACK+ERR=1, RESULT=32'hFFFF_FFFF, RAD_START=0.
//  5 Reset mid-op:
//    RESET for 1 cycle at cycle 10 of ISSUE -> next edge all outputs 0, no ACK.
//    Model keeps FIN=1 -> no grant until FIN=0.
//  6 Stale FIN:
//    RAD_FIN stuck 1 for 3 cycles after ACK -> stays in RELEASE, no new RAD_START until FIN=0.

Source files
------------

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin scheduler that shares one iterative square-root unit among N_REQ requesters.
// Drives the unit's level START/FIN handshake, returns its root and aborts hung operations.
module sqrt_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W_IN    = 64,
    parameter int W_OUT   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*W_IN-1:0]    x_in_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [W_OUT-1:0]         result_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     rad_start_o,
    output logic [W_IN-1:0]          rad_x_o,
    input  logic                     rad_fin_i,
    input  logic [W_OUT-1:0]         rad_count_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     grantId_q, grantId_d;
    logic [W_IN-1:0]   radX_q, radX_d;
    logic              radStart_q, radStart_d;
    logic [W_OUT-1:0]  result_q, result_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;

    logic              grantFound;
    logic [IW-1:0]     grantIdx;
    logic [IW-1:0]     cand;

    // Round-robin search starting at the pointer; first requester found wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!grantFound && req_i[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grantId_q  <= '0;
            radX_q     <= '0;
            radStart_q <= 1'b0;
            result_q   <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grantId_q  <= grantId_d;
            radX_q     <= radX_d;
            radStart_q <= radStart_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grantId_d  = grantId_q;
        radX_d     = radX_q;
        radStart_d = radStart_q;
        result_d   = result_q;
        ack_d      = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // A FIN still high from a previous or aborted op blocks new grants.
                if (!rad_fin_i && grantFound) begin
                    grantId_d  = grantIdx;
                    radX_d     = x_in_i[int'(grantIdx)*W_IN +: W_IN];
                    radStart_d = 1'b1;
                    ptr_d      = IW'((int'(grantIdx) + 1) % N_REQ);
                    cnt_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (rad_fin_i) begin
                    result_d         = rad_count_i;
                    ack_d[grantId_q] = 1'b1;
                    radStart_d       = 1'b0;
                    state_d          = RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d         = '1;
                    ack_d[grantId_q] = 1'b1;
                    err_d            = 1'b1;
                    radStart_d       = 1'b0;
                    state_d          = RELEASE;
                end
            end
            RELEASE: begin
                if (!rad_fin_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        ack_o       = ack_q;
        err_o       = err_q;
        result_o    = result_q;
        grant_id_o  = grantId_q;
        rad_start_o = radStart_q;
        rad_x_o     = radX_q;
    end

endmodule
